// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: decodes the instruction word into register-file/ALU controls, owns the PC
// and stalls PC and writeback for the data-memory busy handshake.
module reg_file_ctrl #(
    parameter int PC_W    = 32,
    parameter int PC_STEP = 4,
    parameter int STALL_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        INSTRUCTION,
    input  logic               BUSYWAIT,
    input  logic               ZERO,
    output logic [PC_W-1:0]    PC,
    output logic [2:0]         READREG1,
    output logic [2:0]         READREG2,
    output logic [2:0]         WRITEREG,
    output logic               WRITEENABLE,
    output logic [7:0]         IMMEDIATE,
    output logic [2:0]         ALUOP,
    output logic               IMM_SEL,
    output logic               NEG_SEL,
    output logic               WB_SEL,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [STALL_W-1:0] STALL_CNT
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, off_ext, seq_pc;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [7:0]         op;
    logic               we_base, is_load, is_store, taken, hold;
    logic               unused_bits;

    assign op          = INSTRUCTION[31:24];
    assign READREG1    = INSTRUCTION[10:8];
    assign READREG2    = INSTRUCTION[2:0];
    assign WRITEREG    = INSTRUCTION[18:16];
    assign IMMEDIATE   = INSTRUCTION[7:0];
    assign unused_bits = ^INSTRUCTION[15:11];

    always_comb begin
        ALUOP    = 3'd0;
        IMM_SEL  = 1'b0;
        NEG_SEL  = 1'b0;
        we_base  = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (op)
            8'd0:  begin we_base = 1'b1; IMM_SEL = 1'b1; end
            8'd1:  we_base = 1'b1;
            8'd2:  begin we_base = 1'b1; ALUOP = 3'd1; end
            8'd3:  begin we_base = 1'b1; ALUOP = 3'd1; NEG_SEL = 1'b1; end
            8'd4:  begin we_base = 1'b1; ALUOP = 3'd2; end
            8'd5:  begin we_base = 1'b1; ALUOP = 3'd3; end
            8'd7:  begin ALUOP = 3'd1; NEG_SEL = 1'b1; end
            8'd8:  begin we_base = 1'b1; is_load = 1'b1; end
            8'd9:  begin we_base = 1'b1; is_load = 1'b1; IMM_SEL = 1'b1; end
            8'd10: is_store = 1'b1;
            8'd11: begin is_store = 1'b1; IMM_SEL = 1'b1; end
            default: ;
        endcase
    end

    // writes are gated by BUSYWAIT so a load commits only on its completing edge
    assign WRITEENABLE = we_base & ~BUSYWAIT & ~RESET;
    assign WB_SEL      = is_load;
    assign MEM_READ    = is_load & ~RESET;
    assign MEM_WRITE   = is_store & ~RESET;

    assign off_ext = {{(PC_W-8){INSTRUCTION[23]}}, INSTRUCTION[23:16]};
    assign seq_pc  = pc_q + PC_W'(PC_STEP);
    assign taken   = (op == 8'd6) | ((op == 8'd7) & ZERO);
    assign hold    = BUSYWAIT & ((state_q == WAIT) | is_load | is_store);
    assign state_d = hold ? WAIT : RUN;
    assign pc_d    = hold ? pc_q : (taken ? seq_pc + (off_ext << 2) : seq_pc);
    assign stall_d = (state_q == WAIT && !(&stall_q)) ? stall_q + STALL_W'(1) : stall_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            pc_q    <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stall_q <= stall_d;
        end
    end

    assign PC        = pc_q;
    assign STALL_CNT = stall_q;
endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl: directed + random stimulus, expected outputs queued by a behavioural model
// and checked by an independent monitor each cycle.
module tb_reg_file_ctrl;
    logic        CLK = 1'b0, RESET = 1'b1, BUSYWAIT = 1'b0, ZERO = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic [31:0] PC;
    logic [2:0]  READREG1, READREG2, WRITEREG, ALUOP;
    logic [7:0]  IMMEDIATE;
    logic        WRITEENABLE, IMM_SEL, NEG_SEL, WB_SEL, MEM_READ, MEM_WRITE;
    logic [15:0] STALL_CNT;

    reg_file_ctrl dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT), .ZERO(ZERO),
        .PC(PC), .READREG1(READREG1), .READREG2(READREG2), .WRITEREG(WRITEREG),
        .WRITEENABLE(WRITEENABLE), .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL),
        .NEG_SEL(NEG_SEL), .WB_SEL(WB_SEL), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned pc, rr1, rr2, wr, we, imm, alu, isel, nsel, wsel, mr, mw, stall;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;
    int unsigned m_pc = 0, m_stall = 0;
    bit          m_wait = 1'b0;
    int unsigned alu_tab [12] = '{0, 0, 1, 1, 2, 3, 0, 1, 0, 0, 0, 0};

    task automatic chk(string name, int unsigned act, int unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // drive one cycle, queue the expected outputs, then advance the model across the edge
    task automatic step(bit rst, logic [31:0] ins, bit busy, bit zero);
        exp_t e;
        int unsigned op;
        bit known, ld, st;
        #1;
        RESET = rst; INSTRUCTION = ins; BUSYWAIT = busy; ZERO = zero;
        op = ins[31:24];
        known = op <= 11;
        ld = op == 8 || op == 9;
        st = op == 10 || op == 11;
        e.pc = m_pc; e.stall = m_stall;
        e.rr1 = ins[10:8]; e.rr2 = ins[2:0]; e.wr = ins[18:16]; e.imm = ins[7:0];
        e.alu = known ? alu_tab[op] : 0;
        e.isel = (op == 0 || op == 9 || op == 11);
        e.nsel = (op == 3 || op == 7);
        e.wsel = ld;
        e.we = (!rst && known && !(op inside {6, 7, 10, 11}) && !busy);
        e.mr = !rst && ld;
        e.mw = !rst && st;
        q.push_back(e);
        if (rst) begin
            m_pc = 0; m_stall = 0; m_wait = 0;
        end else begin
            if (m_wait && m_stall < 65535) m_stall++;
            m_wait = (ld || st) && busy;
            if (!m_wait) begin
                m_pc = m_pc + 4;
                if (op == 6 || (op == 7 && zero)) m_pc = m_pc + 32'($signed(ins[23:16]) * 4);
            end
        end
        @(posedge CLK);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("pc", PC, e.pc);
                chk("readreg1", READREG1, e.rr1);
                chk("readreg2", READREG2, e.rr2);
                chk("writereg", WRITEREG, e.wr);
                chk("writeenable", WRITEENABLE, e.we);
                chk("immediate", IMMEDIATE, e.imm);
                chk("aluop", ALUOP, e.alu);
                chk("imm_sel", IMM_SEL, e.isel);
                chk("neg_sel", NEG_SEL, e.nsel);
                chk("wb_sel", WB_SEL, e.wsel);
                chk("mem_read", MEM_READ, e.mr);
                chk("mem_write", MEM_WRITE, e.mw);
                chk("stall_cnt", STALL_CNT, e.stall);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        @(posedge CLK);
        step(1, 32'h00020005, 0, 0);
        step(1, 32'h00020005, 0, 0);
        step(0, 32'h00020005, 0, 0);
        step(0, 32'h03040102, 0, 0);
        repeat (2) step(0, 32'hFF000000, 0, 0);
        step(0, 32'h07FE0000, 0, 1);
        step(0, 32'hFF000000, 1, 0);
        step(0, 32'h07FE0000, 0, 0);
        step(0, 32'h06020000, 0, 0);
        step(1, 32'h0, 0, 0);
        repeat (2) step(0, 32'hFF000000, 0, 0);
        repeat (3) step(0, 32'h08030001, 1, 0);
        step(0, 32'h08030001, 0, 0);
        step(0, 32'hFF000000, 0, 0);
        step(0, 32'h0B000204, 1, 0);
        step(0, 32'h0B000204, 1, 0);
        step(1, 32'h0B000204, 0, 0);
        step(0, 32'h0A000102, 0, 0);
        step(0, 32'h09050033, 0, 0);
        ins = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (!m_wait) begin
                ins = $urandom;
                ins[31:24] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            end
            step($urandom_range(0, 39) == 0, ins, $urandom_range(0, 1), $urandom_range(0, 1));
        end
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Instruction-side driver of the 8x8 register file: owns the PC, decodes the 32-bit instruction word, and generates register-file read/write addresses, write enable, immediate and ALU/mux controls.
- Sequences the data-memory handshake, stalling PC and register writeback while memory is busy.
- Sits between instruction memory, the register file, the ALU and data memory in the 8-bit CPU.

Parameters:
- PC_W, 32, PC width in bits.
- PC_STEP, 4, byte increment per instruction.
- STALL_W, 16, stall counter width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, synchronous, active-high.
- INSTRUCTION  in  32  current instruction: [31:24] opcode, [23:16] RD/offset, [15:8] RT, [7:0] RS/immediate.
- BUSYWAIT  in  1  data memory busy.
- ZERO  in  1  ALU zero flag.
- PC  out  PC_W  program counter.
- READREG1  out  3  equals INSTRUCTION[10:8].
- READREG2  out  3  equals INSTRUCTION[2:0].
- WRITEREG  out  3  equals INSTRUCTION[18:16].
- WRITEENABLE  out  1  register file write enable.
- IMMEDIATE  out  8  equals INSTRUCTION[7:0].
- ALUOP  out  3  0 fwd, 1 add, 2 and, 3 or.
- IMM_SEL  out  1  1 = ALU operand 2 comes from IMMEDIATE.
- NEG_SEL  out  1  1 = ALU operand 2 is two's-complement negated.
- WB_SEL  out  1  0 = ALU result, 1 = memory read data.
- MEM_READ  out  1  memory read request.
- MEM_WRITE  out  1  memory write request.
- STALL_CNT  out  STALL_W  count of stalled cycles.

Behaviour:
- Opcodes:
  - 0 loadi: fwd, IMM_SEL=1.
  - 1 mov: fwd.
  - 2 add, 3 sub, 4 and, 5 or: sub uses add with NEG_SEL=1.
  - 6 j, 7 beq: beq uses add with NEG_SEL=1.
  - 8 lwd, 9 lwi: lwi has IMM_SEL=1.
  - 10 swd, 11 swi: swi has IMM_SEL=1.
  - Any other opcode is a NOP: no write, no memory request, PC advances.
- WRITEENABLE base value: 1 for opcodes 0-5 and 8-9; 0 for 6, 7, 10, 11 and NOPs.
- Reset (RESET high at posedge):
  - PC=0, state=RUN, STALL_CNT=0.
  - While RESET is high: WRITEENABLE=0, MEM_READ=0, MEM_WRITE=0.
  - Address, immediate and select outputs stay purely combinational from INSTRUCTION.
- FSM states: RUN, WAIT.
  - RUN, non-memory instruction: PC updates every posedge; stays RUN.
  - RUN, memory instruction: MEM_READ (8, 9) or MEM_WRITE (10, 11) asserts combinationally. At posedge, BUSYWAIT=1 moves to WAIT and holds PC; BUSYWAIT=0 completes in one cycle, advances PC and stays RUN.
  - WAIT: MEM_READ/MEM_WRITE held asserted, PC held, STALL_CNT increments each posedge. At the posedge where BUSYWAIT=0, go to RUN and advance PC.
- Load writeback: WRITEENABLE = is_load AND NOT BUSYWAIT, so the register write happens exactly on the completing edge. WB_SEL=1 for loads.
- No register write ever occurs while BUSYWAIT=1.
- Next PC:
  - Default: PC+PC_STEP.
  - j: PC+PC_STEP+(sign_extend(INSTRUCTION[23:16])*4).
  - beq: the same target when ZERO=1, otherwise PC+PC_STEP.
  - Arithmetic is modulo 2^PC_W; wrap-around is permitted, no trap.
- STALL_CNT saturates at all-ones and never wraps.
- RESET while in WAIT: forces RUN and PC=0. MEM_* deassert from that cycle, and no writeback occurs even if BUSYWAIT falls in the same cycle.
- BUSYWAIT high during a non-memory instruction is ignored: no stall.

Test Plan:
- Reset: RESET=1 for 2 edges, INSTRUCTION=0x00020005 (loadi r2,5) -> PC=0, WRITEENABLE=0 and STALL_CNT=0 during reset. After release: WRITEENABLE=1, WRITEREG=2, IMMEDIATE=5, IMM_SEL=1, and PC reaches 4 after one edge.
- Sub decode: INSTRUCTION=0x03040102 -> READREG1=1, READREG2=2, WRITEREG=4, ALUOP=1, NEG_SEL=1, WRITEENABLE=1.
- Branches at PC=0x10:
  - beq with offset 0xFE and ZERO=1 -> PC=0x0C.
  - Same instruction with ZERO=0 -> PC=0x14.
  - j with offset 0x02 -> PC=0x1C.
- Load stall: lwd at PC=8 with BUSYWAIT high for 3 edges, then low:
  - PC held at 8 and WRITEENABLE=0 while BUSYWAIT is high; MEM_READ=1 throughout.
  - WRITEENABLE=1 with WB_SEL=1 in the final cycle.
  - PC=12 and STALL_CNT=3 after completion.
- Reset mid-stall: swi in WAIT, then RESET=1 at the next edge with BUSYWAIT=0 -> PC=0, MEM_WRITE=0, state RUN, no register write.
- Undefined opcode 0xFF -> WRITEENABLE=0, MEM_READ=0, MEM_WRITE=0, PC+=4.
